// File: rtl/spi_master.sv
// SPI master, mode 0 (CPOL=0, CPHA=0), one 8-bit frame per start request.
// Frame timing in units of D = CLK_DIV clk cycles:
//   SETUP (D) -> XFER (16 SCL half-periods, 16D) -> HOLD (D) -> DONE (1 clk)
// so CS_n is low for 18*D cycles. XFER starts with the first SCL rise and
// also contains the trailing low half-period that follows the 8th falling
// edge. The HOLD state is entered only after that half-period has elapsed.
// All outputs come straight from registers.
module spi_master #(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] tx_data,
    input  logic       MISO,
    output logic       SCL,
    output logic       CS_n,
    output logic       MOSI,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       busy
);

    localparam int DW = (CLK_DIV < 2) ? 1 : $clog2(CLK_DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SETUP = 3'd1;
    localparam logic [2:0] S_XFER  = 3'd2;
    localparam logic [2:0] S_HOLD  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]    r_state;
    logic [DW-1:0] r_div;
    logic [2:0]    r_bit;       // index of the bit currently on MOSI (0 = MSB)
    logic          r_tail;      // 8th falling edge done, finishing last low half-period
    logic [7:0]    r_tx;
    logic [7:0]    r_rx_shift;
    logic          r_scl;
    logic          r_cs_n;
    logic          r_mosi;
    logic [7:0]    r_rx_data;
    logic          r_rx_valid;
    logic          r_busy;

    logic          w_div_end;
    logic [2:0]    w_next_bit;

    assign w_div_end  = (r_div == DIV_LAST);
    assign w_next_bit = r_bit + 3'd1;

    assign SCL      = r_scl;
    assign CS_n     = r_cs_n;
    assign MOSI     = r_mosi;
    assign rx_data  = r_rx_data;
    assign rx_valid = r_rx_valid;
    assign busy     = r_busy;

    // Frame sequencer: state, divider, bit counter, shift registers and outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_div      <= '0;
            r_bit      <= 3'd0;
            r_tail     <= 1'b0;
            r_tx       <= 8'h00;
            r_rx_shift <= 8'h00;
            r_scl      <= 1'b0;
            r_cs_n     <= 1'b1;
            r_mosi     <= 1'b0;
            r_rx_data  <= 8'h00;
            r_rx_valid <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_rx_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_scl  <= 1'b0;
                    r_cs_n <= 1'b1;
                    r_mosi <= 1'b0;
                    r_busy <= 1'b0;
                    if (start) begin
                        r_tx    <= tx_data;
                        r_state <= S_SETUP;
                        r_cs_n  <= 1'b0;
                        r_mosi  <= tx_data[7];
                        r_busy  <= 1'b1;
                        r_div   <= '0;
                        r_bit   <= 3'd0;
                        r_tail  <= 1'b0;
                    end
                end
                S_SETUP: begin
                    if (w_div_end) begin
                        // First SCL rise: the slave's MSB is captured here.
                        r_div      <= '0;
                        r_scl      <= 1'b1;
                        r_rx_shift <= {r_rx_shift[6:0], MISO};
                        r_state    <= S_XFER;
                    end else begin
                        r_div <= r_div + 1'b1;
                    end
                end
                S_XFER: begin
                    if (w_div_end) begin
                        r_div <= '0;
                        if (r_scl) begin
                            r_scl <= 1'b0;
                            if (r_bit == 3'd7) begin
                                r_tail <= 1'b1;
                            end else begin
                                r_bit  <= w_next_bit;
                                r_mosi <= r_tx[3'd7 - w_next_bit];
                            end
                        end else if (r_tail) begin
                            r_state <= S_HOLD;
                        end else begin
                            r_scl      <= 1'b1;
                            r_rx_shift <= {r_rx_shift[6:0], MISO};
                        end
                    end else begin
                        r_div <= r_div + 1'b1;
                    end
                end
                S_HOLD: begin
                    if (w_div_end) begin
                        r_div      <= '0;
                        r_state    <= S_DONE;
                        r_cs_n     <= 1'b1;
                        r_mosi     <= 1'b0;
                        r_rx_data  <= r_rx_shift;
                        r_rx_valid <= 1'b1;
                    end else begin
                        r_div <= r_div + 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
